// File: rtl/hex_display_scanner_pkg.sv
// Shared types and constants for the multiplexed 7-segment scanner:
// scan FSM states, the lit-high segment table and a counter-width helper.
package hex_display_scanner_pkg;

    typedef enum logic {
        ST_GAP   = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

    // Segments a..g, index 0 = a, lit = 1.
    localparam logic [0:6] SEG_LUT [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hex_display_scanner_hex7_decode.sv
// Combinational hex nibble to lit-high 7-segment pattern (a..g, index 0 = a).
module hex7_decode
    import hex_display_scanner_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [0:6] seg_lit
);

    assign seg_lit = SEG_LUT[nibble];

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed hex display driver with tear-free load, anti-ghosting gap,
// leading-zero blanking and per-digit blink. All outputs are registered.
module hex_display_scanner
    import hex_display_scanner_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_CYCLES = 50000,
    parameter int GAP_CYCLES   = 16,
    parameter int BLINK_FRAMES = 64,
    parameter int SEG_ACT_LOW  = 1,
    parameter int AN_ACT_LOW   = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blink_en,
    input  logic                    load,
    input  logic                    blank_lz,
    output logic                    pending,
    output logic [0:6]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int CNT_W = cnt_width((DIGIT_CYCLES > GAP_CYCLES) ? DIGIT_CYCLES : GAP_CYCLES);
    localparam int IDX_W = cnt_width(NUM_DIGITS);
    localparam int FRM_W = cnt_width(BLINK_FRAMES);

    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FRM_W-1:0] FRM_LAST   = FRM_W'(BLINK_FRAMES - 1);

    // Off patterns double as XOR masks that convert lit-high to pin polarity.
    localparam logic [0:6]            SEG_OFF = {7{SEG_ACT_LOW != 0}};
    localparam logic                  DP_OFF  = (SEG_ACT_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_ACT_LOW != 0}};

    scan_state_t      state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic             frame_start;

    logic [4*NUM_DIGITS-1:0] pend_value, disp_value;
    logic [NUM_DIGITS-1:0]   pend_dp, disp_dp;
    logic [NUM_DIGITS-1:0]   pend_blink, disp_blink;

    logic [FRM_W-1:0] frame_cnt;
    logic             blink_hidden;

    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  zero_run;
    logic [3:0]            sel_nib;
    logic [0:6]            sel_lit;
    logic                  digit_blanked;
    logic [0:6]            seg_lit_n;
    logic                  dp_lit_n;
    logic [NUM_DIGITS-1:0] an_on_n;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; combinational blocks use blocking (=) with defaults first
    // so no path is left unassigned and no latch is inferred.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_GAP;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt + CNT_W'(1);
        idx_n       = idx;
        frame_start = 1'b0;
        case (state)
            ST_GAP: begin
                if (cnt == GAP_LAST) begin
                    state_n = ST_DRIVE;
                    cnt_n   = '0;
                end
            end
            ST_DRIVE: begin
                if (cnt == DRIVE_LAST) begin
                    state_n = ST_GAP;
                    cnt_n   = '0;
                    if (idx == IDX_LAST) begin
                        idx_n       = '0;
                        frame_start = 1'b1;
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_n = ST_GAP;
                cnt_n   = '0;
                idx_n   = '0;
            end
        endcase
    end

    // Display regs only move at frame start, so a frame is never torn.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend_value <= '0;
            pend_dp    <= '0;
            pend_blink <= '0;
            disp_value <= '0;
            disp_dp    <= '0;
            disp_blink <= '0;
            pending    <= 1'b0;
        end else begin
            if (frame_start && pending) begin
                disp_value <= pend_value;
                disp_dp    <= pend_dp;
                disp_blink <= pend_blink;
            end
            if (load) begin
                pend_value <= value;
                pend_dp    <= dp_in;
                pend_blink <= blink_en;
                pending    <= 1'b1;
            end else if (frame_start) begin
                pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_cnt    <= '0;
            blink_hidden <= 1'b0;
        end else if (frame_start) begin
            if (frame_cnt == FRM_LAST) begin
                frame_cnt    <= '0;
                blink_hidden <= ~blink_hidden;
            end else begin
                frame_cnt <= frame_cnt + FRM_W'(1);
            end
        end
    end

    // Digit k is a leading zero when it and every digit above it are zero.
    always_comb begin
        lz_mask  = '0;
        zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            zero_run   = zero_run && (disp_value[4*k +: 4] == 4'h0);
            lz_mask[k] = zero_run;
        end
    end

    assign sel_nib = disp_value[4*int'(idx_n) +: 4];

    hex7_decode u_decode (
        .nibble  (sel_nib),
        .seg_lit (sel_lit)
    );

    // Outputs are built from the next state so the registered pins switch on
    // the same edge the FSM enters a slot.
    always_comb begin
        digit_blanked = (blank_lz && lz_mask[idx_n]) || (blink_hidden && disp_blink[idx_n]);
        seg_lit_n     = '0;
        dp_lit_n      = 1'b0;
        an_on_n       = '0;
        if (state_n == ST_DRIVE) begin
            an_on_n[idx_n] = 1'b1;
            if (!digit_blanked) begin
                seg_lit_n = sel_lit;
                dp_lit_n  = disp_dp[idx_n];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            seg <= SEG_OFF;
            dp  <= DP_OFF;
            an  <= AN_OFF;
        end else begin
            seg <= seg_lit_n ^ SEG_OFF;
            dp  <= dp_lit_n ^ DP_OFF;
            an  <= an_on_n ^ AN_OFF;
        end
    end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench for hex_display_scanner with 4 digits, 4-clock slots, 2-clock gaps,
// 2-frame blink half-period and active-low pins. Times are clocks since reset release.
module tb_hex_display_scanner;

    localparam logic [0:6] S_OFF = 7'b1111111;
    localparam logic [0:6] S_0   = 7'b0000001;
    localparam logic [0:6] S_1   = 7'b1001111;
    localparam logic [0:6] S_2   = 7'b0010010;
    localparam logic [0:6] S_3   = 7'b0000110;
    localparam logic [0:6] S_4   = 7'b1001100;
    localparam logic [0:6] S_5   = 7'b0100100;
    localparam logic [0:6] S_8   = 7'b0000000;
    localparam logic [0:6] S_A   = 7'b0001000;
    localparam logic [0:6] S_F   = 7'b0111000;

    logic        clk      = 1'b0;
    logic        resetn   = 1'b0;
    logic [15:0] value    = '0;
    logic [3:0]  dp_in    = '0;
    logic [3:0]  blink_en = '0;
    logic        load     = 1'b0;
    logic        blank_lz = 1'b0;
    logic        pending;
    logic [0:6]  seg;
    logic        dp;
    logic [3:0]  an;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    hex_display_scanner #(
        .NUM_DIGITS   (4),
        .DIGIT_CYCLES (4),
        .GAP_CYCLES   (2),
        .BLINK_FRAMES (2),
        .SEG_ACT_LOW  (1),
        .AN_ACT_LOW   (1)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .value    (value),
        .dp_in    (dp_in),
        .blink_en (blink_en),
        .load     (load),
        .blank_lz (blank_lz),
        .pending  (pending),
        .seg      (seg),
        .dp       (dp),
        .an       (an)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // LOAD high for exactly the rising edge that ends clock t.
    task automatic pulse_load(input int t, input logic [15:0] v, input logic [3:0] d,
                              input logic [3:0] b);
        wait_cyc(t - 1);
        value    = v;
        dp_in    = d;
        blink_en = b;
        load     = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (an !== 4'b1111) begin miscompares++; $display("FAIL reset_an: got %b want 1111", an); end
        vectors++;
        if (seg !== S_OFF) begin miscompares++; $display("FAIL reset_seg: got %b want %b", seg, S_OFF); end
        vectors++;
        if (dp !== 1'b1) begin miscompares++; $display("FAIL reset_dp: got %b want 1", dp); end
        vectors++;
        if (pending !== 1'b0) begin miscompares++; $display("FAIL reset_pending: got %b want 0", pending); end
        resetn = 1'b1;
    endtask

    task automatic test_scan();
        logic [3:0] exp_an;
        logic [0:6] exp_seg;
        for (int t = 0; t < 28; t++) begin
            int pos;
            wait_cyc(t);
            pos = t % 24;
            if (pos % 6 < 2) begin
                exp_an  = 4'b1111;
                exp_seg = S_OFF;
            end else begin
                exp_an  = ~(4'b0001 << (pos / 6));
                exp_seg = S_0;
            end
            vectors++;
            if (an !== exp_an) begin miscompares++; $display("FAIL scan_an t=%0d: got %b want %b", t, an, exp_an); end
            vectors++;
            if (seg !== exp_seg) begin miscompares++; $display("FAIL scan_seg t=%0d: got %b want %b", t, seg, exp_seg); end
        end
    endtask

    task automatic test_load_midframe();
        logic [0:6] exp_seg [4];
        logic [3:0] exp_an;
        exp_seg[0] = S_F; exp_seg[1] = S_A; exp_seg[2] = S_2; exp_seg[3] = S_1;
        pulse_load(30, 16'h12AF, 4'b0000, 4'b0000);
        vectors++;
        if (pending !== 1'b1) begin miscompares++; $display("FAIL load_pending_set: got %b want 1", pending); end
        wait_cyc(32);
        vectors++;
        if (seg !== S_0) begin miscompares++; $display("FAIL load_no_tear d1: got %b want %b", seg, S_0); end
        wait_cyc(44);
        vectors++;
        if (seg !== S_0) begin miscompares++; $display("FAIL load_no_tear d3: got %b want %b", seg, S_0); end
        wait_cyc(47);
        vectors++;
        if (pending !== 1'b1) begin miscompares++; $display("FAIL load_pending_hold: got %b want 1", pending); end
        wait_cyc(48);
        vectors++;
        if (pending !== 1'b0) begin miscompares++; $display("FAIL load_pending_clear: got %b want 0", pending); end
        for (int d = 0; d < 4; d++) begin
            wait_cyc(50 + 6 * d);
            exp_an = ~(4'b0001 << d);
            vectors++;
            if (an !== exp_an) begin miscompares++; $display("FAIL load_an d%0d: got %b want %b", d, an, exp_an); end
            vectors++;
            if (seg !== exp_seg[d]) begin miscompares++; $display("FAIL load_seg d%0d: got %b want %b", d, seg, exp_seg[d]); end
        end
    endtask

    task automatic test_leading_zero();
        logic [0:6] exp_seg [4];
        logic       exp_dp  [4];
        logic [3:0] exp_an;
        exp_seg[0] = S_0; exp_seg[1] = S_5; exp_seg[2] = S_OFF; exp_seg[3] = S_OFF;
        exp_dp[0]  = 1'b0; exp_dp[1] = 1'b0; exp_dp[2] = 1'b1; exp_dp[3] = 1'b1;
        wait_cyc(69);
        blank_lz = 1'b1;
        pulse_load(70, 16'h0050, 4'b1111, 4'b0000);
        for (int d = 0; d < 4; d++) begin
            wait_cyc(74 + 6 * d);
            exp_an = ~(4'b0001 << d);
            vectors++;
            if (an !== exp_an) begin miscompares++; $display("FAIL lz_an d%0d: got %b want %b", d, an, exp_an); end
            vectors++;
            if (seg !== exp_seg[d]) begin miscompares++; $display("FAIL lz_seg d%0d: got %b want %b", d, seg, exp_seg[d]); end
            vectors++;
            if (dp !== exp_dp[d]) begin miscompares++; $display("FAIL lz_dp d%0d: got %b want %b", d, dp, exp_dp[d]); end
        end
        wait_cyc(95);
        blank_lz = 1'b0;
        wait_cyc(110);
        vectors++;
        if (seg !== S_0 || dp !== 1'b0) begin
            miscompares++; $display("FAIL lz_off d2: got seg %b dp %b want %b dp 0", seg, dp, S_0);
        end
        wait_cyc(116);
        vectors++;
        if (seg !== S_0 || dp !== 1'b0) begin
            miscompares++; $display("FAIL lz_off d3: got seg %b dp %b want %b dp 0", seg, dp, S_0);
        end
        wait_cyc(117);
        blank_lz = 1'b1;
        pulse_load(118, 16'h0000, 4'b0000, 4'b0000);
        wait_cyc(122);
        vectors++;
        if (seg !== S_0) begin miscompares++; $display("FAIL lz_all_zero d0: got %b want %b", seg, S_0); end
        wait_cyc(128);
        vectors++;
        if (seg !== S_OFF) begin miscompares++; $display("FAIL lz_all_zero d1: got %b want %b", seg, S_OFF); end
        wait_cyc(140);
        vectors++;
        if (seg !== S_OFF) begin miscompares++; $display("FAIL lz_all_zero d3: got %b want %b", seg, S_OFF); end
        wait_cyc(143);
        blank_lz = 1'b0;
    endtask

    task automatic test_back_to_back();
        pulse_load(146, 16'h1111, 4'b0000, 4'b0000);
        pulse_load(150, 16'h2222, 4'b0000, 4'b0000);
        wait_cyc(152);
        vectors++;
        if (seg !== S_0) begin miscompares++; $display("FAIL b2b_no_tear: got %b want %b", seg, S_0); end
        for (int d = 0; d < 4; d++) begin
            wait_cyc(170 + 6 * d);
            vectors++;
            if (seg !== S_2) begin miscompares++; $display("FAIL b2b_last_wins d%0d: got %b want %b", d, seg, S_2); end
        end
        pulse_load(190, 16'h3333, 4'b0000, 4'b0000);
        pulse_load(192, 16'h4444, 4'b0000, 4'b0000);
        vectors++;
        if (pending !== 1'b1) begin miscompares++; $display("FAIL fs_load_pending: got %b want 1", pending); end
        wait_cyc(194);
        vectors++;
        if (seg !== S_3) begin miscompares++; $display("FAIL fs_load_old_applied: got %b want %b", seg, S_3); end
        wait_cyc(215);
        vectors++;
        if (pending !== 1'b1) begin miscompares++; $display("FAIL fs_load_pending_hold: got %b want 1", pending); end
        wait_cyc(216);
        vectors++;
        if (pending !== 1'b0) begin miscompares++; $display("FAIL fs_load_pending_clear: got %b want 0", pending); end
        wait_cyc(218);
        vectors++;
        if (seg !== S_4) begin miscompares++; $display("FAIL fs_load_new_applied: got %b want %b", seg, S_4); end
    endtask

    task automatic test_blink();
        logic [0:6] exp_d0;
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        pulse_load(2, 16'h8888, 4'b0000, 4'b0001);
        vectors++;
        if (seg !== S_0) begin miscompares++; $display("FAIL blink_frame0 d0: got %b want %b", seg, S_0); end
        for (int f = 1; f < 6; f++) begin
            wait_cyc(24 * f + 2);
            exp_d0 = (f == 2 || f == 3) ? S_OFF : S_8;
            vectors++;
            if (an !== 4'b1110 || seg !== exp_d0) begin
                miscompares++;
                $display("FAIL blink_d0 frame%0d: got an %b seg %b want an 1110 seg %b", f, an, seg, exp_d0);
            end
            wait_cyc(24 * f + 8);
            vectors++;
            if (seg !== S_8) begin miscompares++; $display("FAIL blink_d1 frame%0d: got %b want %b", f, seg, S_8); end
        end
    endtask

    task automatic test_reset_midframe();
        pulse_load(133, 16'h5555, 4'b0000, 4'b0000);
        wait_cyc(135);
        vectors++;
        if (an !== 4'b1011 || pending !== 1'b1) begin
            miscompares++; $display("FAIL rst_mid_pre: got an %b pending %b want an 1011 pending 1", an, pending);
        end
        #1 resetn = 1'b0;
        #1;
        vectors++;
        if (an !== 4'b1111) begin miscompares++; $display("FAIL rst_mid_an: got %b want 1111", an); end
        vectors++;
        if (seg !== S_OFF || dp !== 1'b1) begin
            miscompares++; $display("FAIL rst_mid_seg: got seg %b dp %b want %b dp 1", seg, dp, S_OFF);
        end
        vectors++;
        if (pending !== 1'b0) begin miscompares++; $display("FAIL rst_mid_pending: got %b want 0", pending); end
        @(negedge clk);
        resetn = 1'b1;
        wait_cyc(2);
        vectors++;
        if (seg !== S_0 || an !== 4'b1110) begin
            miscompares++; $display("FAIL rst_mid_disp_cleared: got an %b seg %b want an 1110 seg %b", an, seg, S_0);
        end
        wait_cyc(26);
        vectors++;
        if (seg !== S_0) begin miscompares++; $display("FAIL rst_mid_pending_dropped: got %b want %b", seg, S_0); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load_midframe();
        test_leading_zero();
        test_back_to_back();
        test_blink();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
